regfile_mp: RTL and testbench

Multi-port, parametrised register file for the core datapath. It supports NUM_RD combinational read ports and NUM_WR synchronous write ports. Additional features: asynchronous clear of all registers, optional hardwired-zero register 0, optional write-to-read bypass, and a per-register busy scoreboard for tracking in-flight writes. It sits between decode (read/issue) and writeback (write/clear).

---
 rtl/regfile_mp.sv | 140 ++++++++++++++
 tb/tb_regfile_mp.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-port register file with write bypass and busy scoreboard
//
// Register array of 2**ADDR_SIZE words of WORD_SIZE bits. It has NUM_RD
// combinational read ports and NUM_WR synchronous write ports. It also keeps
// a per-register busy scoreboard that decode sets at issue and writeback
// clears.
//
// Ports:
//   clk       rising-edge clock for all state
//   rst       asynchronous active-high clear of registers and busy bits
//   w_en      per-write-port enable
//   waddr     write addresses, port k at [k*ADDR_SIZE +: ADDR_SIZE]
//   wdata     write data, port k at [k*WORD_SIZE +: WORD_SIZE]
//   raddr     read addresses, port i at [i*ADDR_SIZE +: ADDR_SIZE]
//   rdata     read data, port i at [i*WORD_SIZE +: WORD_SIZE]
//   rbusy     registered busy bit of the register each read port addresses
//   iss_en    mark iss_addr busy at the next edge
//   iss_addr  register to mark busy
//   busy_any  OR of all busy bits
module regfile_mp #(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32,
    parameter int NUM_RD    = 2,
    parameter int NUM_WR    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WR-1:0]             w_en,
    input  logic [NUM_WR*ADDR_SIZE-1:0]   waddr,
    input  logic [NUM_WR*WORD_SIZE-1:0]   wdata,
    input  logic [NUM_RD*ADDR_SIZE-1:0]   raddr,
    output logic [NUM_RD*WORD_SIZE-1:0]   rdata,
    output logic [NUM_RD-1:0]             rbusy,
    input  logic                          iss_en,
    input  logic [ADDR_SIZE-1:0]          iss_addr,
    output logic                          busy_any
);

    localparam int DEPTH = 1 << ADDR_SIZE;

    typedef logic [ADDR_SIZE-1:0] addr_t;
    typedef logic [WORD_SIZE-1:0] word_t;

    word_t [DEPTH-1:0] regs;
    logic  [DEPTH-1:0] busy;
    logic  [DEPTH-1:0] busy_next;

    addr_t             wa [NUM_WR];
    word_t             wd [NUM_WR];
    addr_t             ra [NUM_RD];
    logic [NUM_WR-1:0] w_ok;
    logic              iss_ok;
    word_t             rd_v;

    // Unpack the flat port buses. A write or issue to register 0 is dropped
    // here when register 0 is hardwired, so no state for it ever changes.
    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign wa[k]   = waddr[k*ADDR_SIZE +: ADDR_SIZE];
        assign wd[k]   = wdata[k*WORD_SIZE +: WORD_SIZE];
        assign w_ok[k] = w_en[k] && !((ZERO_REG != 0) && (wa[k] == '0));
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        assign ra[i] = raddr[i*ADDR_SIZE +: ADDR_SIZE];
    end

    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // Register array. Ports are visited in ascending order, so the last
    // non-blocking assignment (the highest-index port) wins a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_ok[k]) begin
                    regs[wa[k]] <= wd[k];
                end
            end
        end
    end

    // Scoreboard next state. Writeback clears are applied first and the issue
    // set last, so a same-cycle issue to the register being written back keeps
    // it busy for the new producer.
    always_comb begin
        busy_next = busy;
        for (int k = 0; k < NUM_WR; k++) begin
            if (w_en[k]) begin
                busy_next[wa[k]] = 1'b0;
            end
        end
        if (iss_ok) begin
            busy_next[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Read ports. Bypass forwards the highest-index matching write. The
    // zero-register and reset overrides come last so they beat the bypass.
    // rbusy deliberately looks at the registered busy bits only.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        rd_v  = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_v = regs[ra[i]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (w_en[k] && (wa[k] == ra[i])) begin
                        rd_v = wd[k];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra[i] == '0)) begin
                rd_v = '0;
            end
            if (rst) begin
                rd_v = '0;
            end
            rdata[i*WORD_SIZE +: WORD_SIZE] = rd_v;
            rbusy[i] = rst ? 1'b0 : busy[ra[i]];
        end
    end

    assign busy_any = rst ? 1'b0 : (|busy);

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (bypass and non-bypass builds)
module tb_regfile_mp;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int NW    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NW-1:0]     w_en;
    logic [NW*AW-1:0]  waddr;
    logic [NW*DW-1:0]  wdata;
    logic [NR*AW-1:0]  raddr;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;

    logic [NR*DW-1:0]  rdata,    rdata_nb;
    logic [NR-1:0]     rbusy,    rbusy_nb;
    logic              busy_any, busy_any_nb;

    int checks = 0;
    int errors = 0;

    // Reference state: the architectural register contents and pending set.
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    always #5 clk = ~clk;

    regfile_mp #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .NUM_RD(NR), .NUM_WR(NW),
                 .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_any(busy_any));

    regfile_mp #(.ADDR_SIZE(AW), .WORD_SIZE(DW), .NUM_RD(NR), .NUM_WR(NW),
                 .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .w_en(w_en), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .iss_en(iss_en), .iss_addr(iss_addr), .busy_any(busy_any_nb));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < DEPTH; a++) begin
            m_mem[a]  = '0;
            m_busy[a] = 1'b0;
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        logic [DW-1:0] v;
        if (rst || a == 0) return '0;
        v = m_mem[a];
        if (byp) begin
            for (int k = 0; k < NW; k++) begin
                if (w_en[k] && waddr[k*AW +: AW] == a) v = wdata[k*DW +: DW];
            end
        end
        return v;
    endfunction

    task automatic check_all(input string tag);
        bit any;
        any = 1'b0;
        for (int a = 0; a < DEPTH; a++) any |= m_busy[a];
        for (int i = 0; i < NR; i++) begin
            chk($sformatf("%s_rd%0d", tag, i), {32'h0, rdata[i*DW +: DW]},
                {32'h0, exp_rd(raddr[i*AW +: AW], 1'b1)});
            chk($sformatf("%s_nb_rd%0d", tag, i), {32'h0, rdata_nb[i*DW +: DW]},
                {32'h0, exp_rd(raddr[i*AW +: AW], 1'b0)});
            chk($sformatf("%s_rbusy%0d", tag, i), {63'h0, rbusy[i]},
                {63'h0, (!rst && m_busy[raddr[i*AW +: AW]])});
            chk($sformatf("%s_nb_rbusy%0d", tag, i), {63'h0, rbusy_nb[i]},
                {63'h0, (!rst && m_busy[raddr[i*AW +: AW]])});
        end
        chk({tag, "_busy_any"},    {63'h0, busy_any},    {63'h0, (!rst && any)});
        chk({tag, "_nb_busy_any"}, {63'h0, busy_any_nb}, {63'h0, (!rst && any)});
    endtask

    task automatic idle();
        w_en     = '0;
        waddr    = '0;
        wdata    = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic wr(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        w_en[k]          = 1'b1;
        waddr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    // Advance one clock and apply the architectural effect of the edge.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (w_en[k]) begin
                    if (waddr[k*AW +: AW] != 0) m_mem[waddr[k*AW +: AW]] = wdata[k*DW +: DW];
                    m_busy[waddr[k*AW +: AW]] = 1'b0;
                end
            end
            if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        rd(5'd0, 5'd0);
        model_clear();
        #1;
        check_all("por");
        tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset mid-cycle wipes data and busy bits.
        idle(); wr(0, 5'd5, 32'hDEADBEEF); iss_en = 1'b1; iss_addr = 5'd6;
        rd(5'd5, 5'd6);
        tick();
        idle();
        #1 check_all("pre_rst");
        chk("pre_rst_r5", {32'h0, rdata[31:0]}, 64'hDEADBEEF);
        #2 rst = 1'b1; model_clear();
        #1 check_all("in_rst");
        chk("in_rst_r5", {32'h0, rdata[31:0]}, 64'h0);
        wr(0, 5'd5, 32'h11111111); iss_en = 1'b1; iss_addr = 5'd5;
        tick();
        check_all("rst_held");
        idle();
        rst = 1'b0;
        #1 check_all("rst_rel");
        tick();
        check_all("post_rst");
        chk("post_rst_r5", {32'h0, rdata[31:0]}, 64'h0);

        // Basic write and same-cycle bypass.
        idle(); wr(0, 5'd3, 32'h12345678); rd(5'd3, 5'd3);
        #1 check_all("wr3_cyc");
        chk("wr3_byp", {32'h0, rdata[63:32]}, 64'h12345678);
        chk("wr3_nb_old", {32'h0, rdata_nb[31:0]}, 64'h0);
        tick(); idle();
        #1 check_all("wr3_after");
        chk("wr3_nb_after", {32'h0, rdata_nb[63:32]}, 64'h12345678);

        // Two ports hit r7: port 1 wins both in the array and on the bypass.
        idle(); wr(0, 5'd7, 32'h1); wr(1, 5'd7, 32'h2); rd(5'd7, 5'd3);
        #1 check_all("coll_cyc");
        chk("coll_byp", {32'h0, rdata[31:0]}, 64'h2);
        tick(); idle();
        #1 check_all("coll_after");
        chk("coll_r7", {32'h0, rdata_nb[31:0]}, 64'h2);

        // Register 0 is never written nor marked busy.
        idle(); wr(1, 5'd0, 32'hFFFFFFFF); iss_en = 1'b1; iss_addr = 5'd0; rd(5'd0, 5'd0);
        #1 check_all("zero_cyc");
        tick(); idle();
        #1 check_all("zero_after");
        chk("zero_busy_any", {63'h0, busy_any}, 64'h0);

        // Scoreboard: issue, writeback, then issue+writeback together.
        idle(); iss_en = 1'b1; iss_addr = 5'd9; rd(5'd9, 5'd9);
        tick(); idle();
        #1 check_all("sb_iss");
        chk("sb_iss_rbusy", {63'h0, rbusy[0]}, 64'h1);
        wr(0, 5'd9, 32'hA5);
        #1 check_all("sb_wb_cyc");
        chk("sb_wb_still_busy", {63'h0, rbusy[1]}, 64'h1);
        tick(); idle();
        #1 check_all("sb_wb");
        chk("sb_wb_rdata", {32'h0, rdata[31:0]}, 64'hA5);
        chk("sb_wb_free", {63'h0, busy_any}, 64'h0);
        iss_en = 1'b1; iss_addr = 5'd9;
        tick(); idle();
        iss_en = 1'b1; iss_addr = 5'd9; wr(1, 5'd9, 32'h5A);
        tick(); idle();
        #1 check_all("sb_both");
        chk("sb_both_busy", {63'h0, rbusy[0]}, 64'h1);

        // Non-bypass build shows the old value until after the edge.
        idle(); wr(0, 5'd4, 32'h55); rd(5'd4, 5'd9);
        #1 check_all("nb_cyc");
        chk("nb_old", {32'h0, rdata_nb[31:0]}, 64'h0);
        tick(); idle();
        #1 check_all("nb_after");
        chk("nb_new", {32'h0, rdata_nb[31:0]}, 64'h55);

        // Randomized traffic over a small address window to force collisions.
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom_range(0, 59) == 0);
            if (rst) model_clear();
            for (int k = 0; k < NW; k++) begin
                if ($urandom_range(0, 1) == 1) wr(k, AW'($urandom_range(0, 7)), $urandom);
            end
            iss_en   = ($urandom_range(0, 2) == 0);
            iss_addr = AW'($urandom_range(0, 7));
            rd(AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
            #1 check_all("rnd");
            tick();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
